// File: rtl/uart_hex_loader.sv
// UART receiver plus hex-record parser: decodes "$AAAA#HH HH ... CR" lines
// into single-byte writes for a block RAM write port.
module uart_hex_loader #(
   parameter int CLK_HZ = 24000000,
   parameter int BAUD   = 115200,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              RESET,
   input  logic              rx,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic              rec_done,
   output logic              err,
   output logic              busy
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = $clog2(DIV + 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(DIV - 1);
   localparam logic [CW-1:0] HALF_M1 = CW'(DIV / 2 - 1);

   localparam logic [7:0] CH_DOLLAR = 8'h24;
   localparam logic [7:0] CH_HASH   = 8'h23;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_CR     = 8'h0D;

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {P_HUNT, P_ADDR, P_HASH, P_DHI, P_DLO, P_SEP} p_state_t;

   // Returns {valid, nibble} for 0-9, A-F, a-f.
   function automatic logic [4:0] hex_val(input logic [7:0] c);
      if (c >= 8'h30 && c <= 8'h39)
         return {1'b1, c[3:0]};
      else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
         return {1'b1, c[3:0] + 4'd9};
      else
         return 5'd0;
   endfunction

   logic          rx_s1, rx_s2, rx_d;
   rx_state_t     r_state, r_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    bit_idx, bit_next;
   logic [7:0]    sh, sh_next;
   // rx_valid is a one-cycle pulse with sh holding the byte; the parser
   // always accepts, so there is no ready and nothing is ever held.
   logic          rx_valid, frame_err;

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         rx_s1   <= 1'b1;
         rx_s2   <= 1'b1;
         rx_d    <= 1'b1;
         r_state <= R_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         sh      <= '0;
      end else begin
         rx_s1   <= rx;
         rx_s2   <= rx_s1;
         rx_d    <= rx_s2;
         r_state <= r_next;
         cnt     <= cnt_next;
         bit_idx <= bit_next;
         sh      <= sh_next;
      end
   end

   always_comb begin
      r_next    = r_state;
      cnt_next  = cnt;
      bit_next  = bit_idx;
      sh_next   = sh;
      rx_valid  = 1'b0;
      frame_err = 1'b0;
      case (r_state)
         R_IDLE: begin
            if (rx_d && !rx_s2) begin
               r_next   = R_START;
               cnt_next = '0;
            end
         end
         R_START: begin
            if (cnt == HALF_M1) begin
               cnt_next = '0;
               bit_next = '0;
               r_next   = rx_s2 ? R_IDLE : R_DATA;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         R_DATA: begin
            if (cnt == FULL_M1) begin
               cnt_next = '0;
               sh_next  = {rx_s2, sh[7:1]};
               bit_next = bit_idx + 1'b1;
               if (bit_idx == 3'd7) r_next = R_STOP;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         R_STOP: begin
            if (cnt == FULL_M1) begin
               cnt_next  = '0;
               rx_valid  = rx_s2;
               frame_err = !rx_s2;
               r_next    = R_IDLE;
            end else begin
               cnt_next = cnt + 1'b1;
            end
         end
         default: r_next = R_IDLE;
      endcase
   end

   p_state_t          p_state, p_next;
   logic [ADDR_W-1:0] acc, acc_n, addr_n;
   logic [1:0]        dcnt, dcnt_n;
   logic [3:0]        hi, hi_n;
   logic [4:0]        count, count_n;
   logic [7:0]        data_n;
   logic              wen_n, done_n, perr, perr_n, bad;
   logic [4:0]        hv;

   always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
         p_state  <= P_HUNT;
         acc      <= '0;
         dcnt     <= '0;
         hi       <= '0;
         count    <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         rec_done <= 1'b0;
         perr     <= 1'b0;
      end else begin
         p_state  <= p_next;
         acc      <= acc_n;
         dcnt     <= dcnt_n;
         hi       <= hi_n;
         count    <= count_n;
         wr_en    <= wen_n;
         wr_addr  <= addr_n;
         wr_data  <= data_n;
         rec_done <= done_n;
         perr     <= perr_n;
      end
   end

   always_comb begin
      p_next  = p_state;
      acc_n   = acc;
      dcnt_n  = dcnt;
      hi_n    = hi;
      count_n = count;
      addr_n  = wr_en ? wr_addr + 1'b1 : wr_addr;
      data_n  = wr_data;
      wen_n   = 1'b0;
      done_n  = 1'b0;
      perr_n  = 1'b0;
      bad     = 1'b0;
      hv      = hex_val(sh);
      if (frame_err) begin
         p_next = P_HUNT;
      end else if (rx_valid) begin
         if (sh == CH_DOLLAR) begin
            perr_n  = (p_state != P_HUNT);
            p_next  = P_ADDR;
            acc_n   = '0;
            dcnt_n  = '0;
            count_n = '0;
         end else begin
            case (p_state)
               P_HUNT: ;
               P_ADDR: begin
                  if (hv[4]) begin
                     // Only the low ADDR_W bits of the 16-bit address survive.
                     acc_n  = ADDR_W'({acc, hv[3:0]});
                     dcnt_n = dcnt + 1'b1;
                     if (dcnt == 2'd3) p_next = P_HASH;
                  end else bad = 1'b1;
               end
               P_HASH: begin
                  if (sh == CH_HASH) begin
                     addr_n = acc;
                     p_next = P_DHI;
                  end else bad = 1'b1;
               end
               P_DHI: begin
                  if (hv[4] && count != 5'd16) begin
                     hi_n   = hv[3:0];
                     p_next = P_DLO;
                  end else if (sh == CH_CR) begin
                     done_n = 1'b1;
                     p_next = P_HUNT;
                  end else bad = 1'b1;
               end
               P_DLO: begin
                  if (hv[4]) begin
                     data_n  = {hi, hv[3:0]};
                     wen_n   = 1'b1;
                     count_n = count + 1'b1;
                     p_next  = P_SEP;
                  end else bad = 1'b1;
               end
               P_SEP: begin
                  if (sh == CH_SPACE) begin
                     p_next = P_DHI;
                  end else if (sh == CH_CR) begin
                     done_n = 1'b1;
                     p_next = P_HUNT;
                  end else bad = 1'b1;
               end
               default: bad = 1'b1;
            endcase
            if (bad) begin
               perr_n = 1'b1;
               p_next = P_HUNT;
            end
         end
      end
   end

   assign err  = perr | frame_err;
   assign busy = (p_state != P_HUNT) && !frame_err;

endmodule

// File: tb/tb_uart_hex_loader.sv
// Directed bench for uart_hex_loader: serial records in, BRAM writes and
// status pulses checked against hand-computed expectations.
`timescale 1ns/1ps
module tb_uart_hex_loader;
   localparam int CLK_HZ   = 1_843_200;
   localparam int BAUD     = 115_200;
   localparam int DIV      = 16;
   localparam int ADDR_W   = 10;
   // 2 synchronizer cycles + half bit + 9 full bits = 154
   localparam int STOP_LAT = 154;

   logic              clk   = 1'b0;
   logic              RESET = 1'b1;
   logic              rx    = 1'b1;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic              rec_done, err, busy;

   uart_hex_loader #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .RESET(RESET), .rx(rx),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rec_done(rec_done), .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   int          checks = 0, failures = 0;
   logic [17:0] exp_q[$];
   logic [17:0] exp_w;
   int          n_wr = 0, n_done = 0, n_err = 0, n_rxv = 0;
   int          b_wr, b_done, b_err, b_rxv;
   int          cyc = 0, err_cyc = -1, start_cyc = 0;
   logic        prev_wr = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Clock/reset-side observer: scoreboard for writes plus pulse invariants.
   always @(negedge clk) begin
      if (!RESET) begin
         if (dut.rx_valid) n_rxv++;
         if (err) begin n_err++; err_cyc = cyc; end
         if (rec_done) n_done++;
         if (err || rec_done) begin
            checks++;
            assert (!(err && rec_done)) else begin
               failures++;
               $error("FAIL err_and_done got=%b%b exp=not both", err, rec_done);
            end
         end
         if (wr_en) begin
            n_wr++;
            if (exp_q.size() != 0) exp_w = exp_q.pop_front();
            else exp_w = 'x;
            checks++;
            assert ({wr_addr, wr_data} === exp_w) else begin
               failures++;
               $error("FAIL write got=%h/%h exp=%h/%h", wr_addr, wr_data, exp_w[17:8], exp_w[7:0]);
            end
            checks++;
            assert (prev_wr === 1'b0) else begin
               failures++;
               $error("FAIL wr_en_back_to_back got=%b exp=0", prev_wr);
            end
         end
      end
      prev_wr = wr_en;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      assert (got === expv) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, expv);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      start_cyc = cyc;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (DIV) @(negedge clk);
      end
      rx = stop_bit;
      repeat (DIV) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
   endtask

   task automatic send_cr();
      send_byte(8'h0D, 1'b1);
   endtask

   task automatic mark();
      b_wr = n_wr; b_done = n_done; b_err = n_err; b_rxv = n_rxv;
   endtask

   function automatic logic [7:0] hexc(input int n);
      return (n < 10) ? 8'(8'h30 + n) : 8'(8'h37 + n);
   endfunction

   initial begin
      repeat (4) @(negedge clk);
      check("rst_wr_en", wr_en, 0);
      check("rst_wr_addr", wr_addr, 0);
      check("rst_wr_data", wr_data, 0);
      check("rst_rec_done", rec_done, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      RESET = 1'b0;
      repeat (4) @(negedge clk);

      // basic four-byte record
      mark();
      exp_q.push_back({10'h010, 8'h4D});
      exp_q.push_back({10'h011, 8'h40});
      exp_q.push_back({10'h012, 8'h7F});
      exp_q.push_back({10'h013, 8'hFC});
      send_byte(8'h24, 1'b1);
      check("t1_busy_up", busy, 1);
      send_str("0010#4D 40 7F FC ");
      send_cr();
      check("t1_writes", n_wr - b_wr, 4);
      check("t1_done", n_done - b_done, 1);
      check("t1_err", n_err - b_err, 0);
      check("t1_busy_down", busy, 0);
      check("t1_queue", exp_q.size(), 0);

      // full 16-byte line up to the top of the address space
      mark();
      send_str("$03F0#");
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({10'(10'h3F0 + i), 8'(i)});
         send_byte(8'h30, 1'b1);
         send_byte(hexc(i), 1'b1);
         send_byte(8'h20, 1'b1);
      end
      send_cr();
      check("t2_writes", n_wr - b_wr, 16);
      check("t2_done", n_done - b_done, 1);
      check("t2_err", n_err - b_err, 0);
      check("t2_queue", exp_q.size(), 0);

      // address wrap, mixed-case digits
      mark();
      exp_q.push_back({10'h3FF, 8'hAA});
      exp_q.push_back({10'h000, 8'hBB});
      send_str("$03fF#aA Bb ");
      send_cr();
      check("t3_writes", n_wr - b_wr, 2);
      check("t3_done", n_done - b_done, 1);
      check("t3_err", n_err - b_err, 0);
      check("t3_queue", exp_q.size(), 0);
      check("t3_addr_after", wr_addr, 10'h001);

      // syntax error mid-record, then trailing junk ignored
      mark();
      exp_q.push_back({10'h000, 8'h12});
      send_str("$0000#12 3G");
      check("t4_writes", n_wr - b_wr, 1);
      check("t4_err", n_err - b_err, 1);
      check("t4_busy", busy, 0);
      send_str(" 45 67");
      send_cr();
      check("t4_trail_writes", n_wr - b_wr, 1);
      check("t4_trail_err", n_err - b_err, 1);
      check("t4_trail_done", n_done - b_done, 0);
      check("t4_queue", exp_q.size(), 0);

      // framing error on the '#' byte
      mark();
      send_str("$0020");
      err_cyc = -1;
      send_byte(8'h23, 1'b0);
      check("t5_err", n_err - b_err, 1);
      check("t5_err_latency", err_cyc - start_cyc, STOP_LAT);
      check("t5_busy", busy, 0);
      send_str("11 ");
      send_cr();
      check("t5_writes", n_wr - b_wr, 0);
      check("t5_done", n_done - b_done, 0);
      exp_q.push_back({10'h020, 8'h5A});
      send_str("$0020#5A ");
      send_cr();
      check("t5_next_writes", n_wr - b_wr, 1);
      check("t5_next_done", n_done - b_done, 1);
      check("t5_next_err", n_err - b_err, 1);

      // 17th byte rejected
      mark();
      send_str("$0100#");
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({10'(10'h100 + i), 8'(8'h80 + i)});
         send_byte(8'h38, 1'b1);
         send_byte(hexc(i), 1'b1);
         send_byte(8'h20, 1'b1);
      end
      send_str("90");
      send_cr();
      check("t6_writes", n_wr - b_wr, 16);
      check("t6_err", n_err - b_err, 1);
      check("t6_done", n_done - b_done, 0);
      check("t6_busy", busy, 0);
      check("t6_queue", exp_q.size(), 0);

      // short low glitch on idle line, then a healthy record
      mark();
      rx = 1'b0;
      repeat (3) @(negedge clk);
      rx = 1'b1;
      repeat (3 * DIV) @(negedge clk);
      check("t7_glitch_rxv", n_rxv - b_rxv, 0);
      check("t7_glitch_err", n_err - b_err, 0);
      check("t7_glitch_busy", busy, 0);
      exp_q.push_back({10'h030, 8'hC3});
      send_str("$0030#C3 ");
      send_cr();
      check("t7_writes", n_wr - b_wr, 1);
      check("t7_done", n_done - b_done, 1);

      // reset while the second data byte is on the wire
      mark();
      exp_q.push_back({10'h040, 8'h12});
      send_str("$0040#12 3");
      check("t8_pre_queue", exp_q.size(), 0);
      rx = 1'b0;
      repeat (DIV) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = 1'(8'h34 >> i);
         repeat (DIV) @(negedge clk);
      end
      RESET = 1'b1;
      rx = 1'b1;
      repeat (3) @(negedge clk);
      check("t8_rst_wr_en", wr_en, 0);
      check("t8_rst_wr_addr", wr_addr, 0);
      check("t8_rst_wr_data", wr_data, 0);
      check("t8_rst_busy", busy, 0);
      check("t8_rst_err", err, 0);
      check("t8_rst_done", rec_done, 0);
      RESET = 1'b0;
      repeat (12 * DIV) @(negedge clk);
      check("t8_after_writes", n_wr - b_wr, 1);
      check("t8_after_err", n_err - b_err, 0);
      check("t8_after_done", n_done - b_done, 0);
      check("t8_after_busy", busy, 0);
      exp_q.push_back({10'h005, 8'hEE});
      send_str("$0005#EE ");
      send_cr();
      check("t8_fresh_writes", n_wr - b_wr, 2);
      check("t8_fresh_done", n_done - b_done, 1);
      check("t8_fresh_queue", exp_q.size(), 0);

      repeat (4) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
